// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate tester: command codes, vector memory map
// and the responder state encoding.
package gate_tester_pkg;

  localparam logic [7:0]  CMD_READ     = 8'h00;
  localparam logic [7:0]  CMD_WRITE    = 8'h01;

  localparam logic [15:0] DUT_VEC_ADDR = 16'h0000;
  localparam logic [15:0] INPUT_ADDR   = 16'h0008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_FETCH,
    ST_READ_HOLD
  } resp_state_e;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port byte memory: synchronous write, registered read with enable.
// The array itself is never reset so vectors survive a controller reset.
module byte_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output register holds its value while re_i is low, which keeps the
  // presented byte stable for the whole handshake wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gate_mem_responder.sv
// Services read/write commands from the verification controller against the
// test-vector byte memory; writes take bytes from the UART receiver.
module gate_mem_responder
  import gate_tester_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [7:0]        command,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              rx_byte_valid,
  input  logic [DATA_W-1:0] rx_byte,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_byte_valid,
  input  logic              tx_byte_ready,
  output logic              rx_done,
  output logic              tx_done,
  output logic              busy,
  output logic              cmd_err
);

  localparam int PTR_W = $clog2(DEPTH);

  resp_state_e       state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  end_q;
  logic              tx_valid_q;
  logic              rx_done_q;
  logic              tx_done_q;
  logic              busy_q;
  logic              cmd_err_q;

  logic              cmd_ok;
  logic              ram_we;
  logic              ram_re;

  // Full-width range check; once it passes, the low bits alone address memory.
  assign cmd_ok = cmd_known(command) && (start_addr <= end_addr) &&
                  (end_addr < ADDR_W'(DEPTH));

  assign ram_we = (state_q == ST_WRITE) && rx_byte_valid;
  assign ram_re = (state_q == ST_READ_FETCH);

  byte_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ptr_q),
    .wdata_i (rx_byte),
    .rdata_o (tx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      end_q      <= '0;
      tx_valid_q <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (!cmd_ok) begin
              cmd_err_q <= 1'b1;
            end else begin
              ptr_q   <= start_addr[PTR_W-1:0];
              end_q   <= end_addr[PTR_W-1:0];
              busy_q  <= 1'b1;
              state_q <= (command == CMD_WRITE) ? ST_WRITE : ST_READ_FETCH;
            end
          end
        end
        ST_WRITE: begin
          if (rx_byte_valid) begin
            if (ptr_q == end_q) begin
              rx_done_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        // The RAM output register captures mem[ptr] on this same edge.
        ST_READ_FETCH: begin
          tx_valid_q <= 1'b1;
          state_q    <= ST_READ_HOLD;
        end
        ST_READ_HOLD: begin
          if (tx_byte_ready) begin
            tx_valid_q <= 1'b0;
            if (ptr_q == end_q) begin
              tx_done_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= ST_READ_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_byte_valid = tx_valid_q;
  assign rx_done       = rx_done_q;
  assign tx_done       = tx_done_q;
  assign busy          = busy_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: doc/gate_mem_responder.md
Name: gate_mem_responder

Overview:
- Processor-side responder that services read/write commands issued by the verification controller against the test-vector byte memory.
- Write command (8'h01): stores incoming UART receive bytes from start_addr to end_addr, then pulses rx_done.
- Read command (8'h00): streams the stored bytes from start_addr to end_addr out on tx_byte with a valid/ready handshake, then pulses tx_done.
- Sits between the UART receiver, the verification controller and the byte memory holding DUT vectors (addr 0x0000) and input patterns (addr 0x0008).

Parameters:
- ADDR_W, 16, width of start/end address ports.
- DEPTH, 16, number of byte locations in the memory (legal addresses 0..DEPTH-1).
- DATA_W, 8, memory word and byte width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle strobe: command and addresses are valid.
- command  in  8  8'h00 = read, 8'h01 = write; any other value is illegal.
- start_addr  in  ADDR_W  first byte address, inclusive.
- end_addr  in  ADDR_W  last byte address, inclusive.
- rx_byte_valid  in  1  one-cycle strobe from the UART receiver.
- rx_byte  in  DATA_W  received byte.
- tx_byte  out  DATA_W  byte being read out.
- tx_byte_valid  out  1  tx_byte holds a valid byte.
- tx_byte_ready  in  1  consumer accepts tx_byte this cycle.
- rx_done  out  1  one-cycle pulse after the last write byte is stored.
- tx_done  out  1  one-cycle pulse after the last read byte is accepted.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ptr=0.
  - tx_byte=0; tx_byte_valid, rx_done, tx_done, busy and cmd_err all 0.
  - Memory contents are not reset; they are preserved across reset.
- States: IDLE, WRITE, READ_FETCH, READ_HOLD.
- IDLE, cmd_valid=1:
  - Rejected when command is neither 8'h00 nor 8'h01, or start_addr>end_addr, or end_addr>=DEPTH. The command is dropped, cmd_err pulses the next cycle, and the state stays IDLE.
  - Write accepted: ptr<=start_addr, state becomes WRITE.
  - Read accepted: ptr<=start_addr, state becomes READ_FETCH.
- WRITE:
  - On rx_byte_valid, mem[ptr]<=rx_byte.
  - If ptr==end_addr (latched at accept), rx_done pulses the next cycle and the state returns to IDLE. Otherwise ptr increments.
  - Cycles without rx_byte_valid hold state; there is no timeout.
- READ_FETCH:
  - Synchronous memory read of mem[ptr]; the next cycle loads tx_byte, sets tx_byte_valid=1 and moves to READ_HOLD.
  - Latency from accepted cmd_valid to first tx_byte_valid is 2 cycles.
- READ_HOLD:
  - tx_byte and tx_byte_valid hold stable until tx_byte_ready=1.
  - On handshake with ptr==end_addr: tx_byte_valid drops, tx_done pulses, state becomes IDLE.
  - Otherwise: ptr increments, tx_byte_valid drops, state becomes READ_FETCH.
  - Throughput is therefore 1 byte per 2 cycles.
- cmd_valid outside IDLE is ignored; cmd_err does not fire.
- rx_byte_valid outside WRITE is ignored and memory is unchanged.
- Single-byte transfer (start==end) completes after one byte.
- Address arithmetic:
  - ptr is $clog2(DEPTH) bits wide; end_addr is compared after the range check, so ptr never wraps.
  - Upper ADDR_W bits are checked only in the range check.
- Reset mid-operation aborts the transfer and returns to IDLE without a done pulse. Bytes already written stay in memory.
- rx_done and tx_done are never high in the same cycle.

Decomposition:
- Shared package gate_tester_pkg:
  - CMD_READ=8'h00, CMD_WRITE=8'h01.
  - DUT_VEC_ADDR=16'h0000, INPUT_ADDR=16'h0008.
  - responder state enum.
- Sub-module byte_ram: DEPTH x DATA_W, synchronous write, registered synchronous read, no reset on the array.
- The controller FSM lives in gate_mem_responder.

Test Plan:
- Write 16'h0008..16'h0008; send rx_byte 8'hE4 -> mem[8]=8'hE4, rx_done pulses once, busy drops the same cycle rx_done rises.
- Read 16'h0008..16'h0008 after that write, tx_byte_ready=1 -> tx_byte_valid rises 2 cycles after cmd_valid with tx_byte=8'hE4, then tx_done pulses.
- Write 0..3 with bytes 8'h11,8'h22,8'h33,8'h44, then read 0..3 holding tx_byte_ready=0 for 5 cycles on each byte -> tx_byte stays stable while waiting, bytes come out in order 11,22,33,44, tx_done fires once after 8'h44.
- Illegal command 8'h02, then start=5/end=3, then end=16 -> cmd_err pulses for each, busy stays 0, memory is unchanged.
- rst_n low after the 2nd of 4 write bytes -> state IDLE, no rx_done, the first 2 bytes are retained; a following read of those addresses returns them.
- cmd_valid during an active read, and rx_byte_valid in IDLE -> both ignored, the read completes unchanged, memory is unmodified.
